// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative RISC-V M-extension unit, radix-2 shift-add multiply and restoring divide.
// Optional feature macro: MULDIV_EARLY_OUT_EN lets divide-by-zero and signed overflow skip the iteration.
module mult_div_unit #(
  parameter int parallelism = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             opCode,
  input  logic                   valid,
  input  logic [parallelism-1:0] lOp,
  input  logic [parallelism-1:0] rOp,
  output logic [parallelism-1:0] result,
  output logic                   done,
  output logic                   divByZero,
  output logic                   divOverflow
);
  localparam int W = parallelism;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state, state_nx;
  logic [2:0] op;
  logic neg, dz, ov;
  logic [W-1:0] a, l_raw;
  logic [2*W-1:0] acc, acc_nx, prod;
  logic [CW-1:0] cnt;
  logic start, l_sgn, r_sgn, neg_l, neg_r, cap_dz, cap_ov, special;
  logic [W-1:0] l_mag, r_mag, quo, rem, fin_res;
  logic [W:0] msum, dshift, ddiff;
  // a new op is accepted only in IDLE and never in the cycle done is shown
  assign start = (state == IDLE) && valid && !done;
  assign l_sgn = (opCode == 3'b001) || (opCode == 3'b010) || (opCode == 3'b100) || (opCode == 3'b110);
  assign r_sgn = (opCode == 3'b001) || (opCode == 3'b100) || (opCode == 3'b110);
  assign neg_l = l_sgn && lOp[W-1];
  assign neg_r = r_sgn && rOp[W-1];
  assign l_mag = neg_l ? -lOp : lOp;
  assign r_mag = neg_r ? -rOp : rOp;
  assign cap_dz = opCode[2] && (rOp == '0);
  assign cap_ov = opCode[2] && !opCode[0] && (lOp == {1'b1, {(W-1){1'b0}}}) && (rOp == '1);
`ifdef MULDIV_EARLY_OUT_EN
  assign special = cap_dz || cap_ov;
`else
  assign special = 1'b0;
`endif
  // multiply step: add multiplicand into the high half when the low bit is set, then shift right
  assign msum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a} : '0);
  // divide step: shift the next dividend bit into the remainder and try subtracting the divisor
  assign dshift = acc[2*W-1:W-1];
  assign ddiff = dshift - {1'b0, a};
  assign acc_nx = op[2] ? (ddiff[W] ? {dshift[W-1:0], acc[W-2:0], 1'b0} : {ddiff[W-1:0], acc[W-2:0], 1'b1})
                        : {msum, acc[W-1:1]};
  // sign fix and special-case override applied while in FIN
  assign prod = neg ? -acc : acc;
  assign quo = neg ? -acc[W-1:0] : acc[W-1:0];
  assign rem = neg ? -acc[2*W-1:W] : acc[2*W-1:W];
  assign fin_res = !op[2] ? ((op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W]) :
                   dz ? (op[1] ? l_raw : '1) :
                   ov ? (op[1] ? '0 : {1'b1, {(W-1){1'b0}}}) :
                   op[1] ? rem : quo;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: IDLE -> CALC (or FIN on early-out) -> FIN -> IDLE
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start ? (special ? FIN : CALC) : IDLE;
    else if (state == CALC) state_nx = (cnt == '0) ? FIN : CALC;
    else state_nx = IDLE;
  end
  // operand capture, iteration and result/flag registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= '0;
      neg <= 1'b0;
      dz <= 1'b0;
      ov <= 1'b0;
      a <= '0;
      l_raw <= '0;
      acc <= '0;
      cnt <= '0;
      result <= '0;
      divByZero <= 1'b0;
      divOverflow <= 1'b0;
    end else if (start) begin
      op <= opCode;
      neg <= (opCode[2] && opCode[1]) ? neg_l : (neg_l ^ neg_r);
      dz <= cap_dz;
      ov <= cap_ov;
      a <= opCode[2] ? r_mag : l_mag;
      l_raw <= lOp;
      acc <= {{W{1'b0}}, opCode[2] ? l_mag : r_mag};
      cnt <= CW'(W - 1);
      divByZero <= 1'b0;
      divOverflow <= 1'b0;
    end else if (state == CALC) begin
      acc <= acc_nx;
      cnt <= cnt - CW'(1);
    end else if (state == FIN) begin
      result <= fin_res;
      divByZero <= dz;
      divOverflow <= ov;
    end
  // done is a one-cycle pulse following the FIN cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) done <= 1'b0;
    else done <= (state == FIN);
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with a scoreboard queue and a done-driven monitor.
module tb_mult_div_unit;
  localparam int W = 32;
  localparam int LAT = W + 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SLAT = 1;
`else
  localparam int SLAT = W + 1;
`endif
  typedef struct {
    string name;
    logic [W-1:0] res;
    logic dz;
    logic ov;
    int lat;
    int cap;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] opCode = '0;
  logic valid = 1'b0;
  logic [W-1:0] lOp = '0;
  logic [W-1:0] rOp = '0;
  logic [W-1:0] result;
  logic done, divByZero, divOverflow;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  exp_t sb[$];
  mult_div_unit #(.parallelism(W)) dut (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .valid(valid), .lOp(lOp), .rOp(rOp),
    .result(result), .done(done), .divByZero(divByZero), .divOverflow(divOverflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got result %h, required no done", result);
      end else begin
        e = sb.pop_front();
        check({e.name, "_res"}, result, e.res);
        check({e.name, "_dz"}, {31'b0, divByZero}, {31'b0, e.dz});
        check({e.name, "_ov"}, {31'b0, divOverflow}, {31'b0, e.ov});
        check({e.name, "_lat"}, cyc - e.cap, e.lat);
      end
    end
  end
  task automatic issue(string name, logic [2:0] op, logic [W-1:0] l, logic [W-1:0] r,
                       logic [W-1:0] res, logic dz, logic ov, int lat);
    exp_t e;
    @(negedge clk);
    opCode = op;
    lOp = l;
    rOp = r;
    valid = 1'b1;
    e.name = name;
    e.res = res;
    e.dz = dz;
    e.ov = ov;
    e.lat = lat;
    e.cap = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    valid = 1'b0;
  endtask
  task automatic wait_done(string name, bit poke);
    int k = 0;
    exp_t d;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: got no done, required done within 100 cycles", name);
      if (sb.size() > 0) d = sb.pop_back();
    end
    if (poke) begin
      opCode = 3'b000;
      lOp = 32'd9;
      rOp = 32'd9;
      valid = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0;
    check({name, "_done_width"}, {31'b0, done}, 32'd0);
  endtask
  task automatic run(string name, logic [2:0] op, logic [W-1:0] l, logic [W-1:0] r,
                     logic [W-1:0] res, logic dz, logic ov, int lat);
    issue(name, op, l, r, res, dz, ov, lat);
    wait_done(name, 1'b0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dz", {31'b0, divByZero}, 32'd0);
    check("rst_ov", {31'b0, divOverflow}, 32'd0);
    rst_n = 1'b1;
    run("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, LAT);
    run("mul_ffx2", 3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, LAT);
    run("mul_m3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 1'b0, LAT);
    run("mulh_m1xm1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, LAT);
    run("mulh_m3x5", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, LAT);
    run("mulhu_ffxff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, LAT);
    run("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, LAT);
    run("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, LAT);
    run("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, LAT);
    run("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, LAT);
    run("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, LAT);
    run("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, LAT);
    run("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, LAT);
    run("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, SLAT);
    run("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, SLAT);
    run("div_m7_0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, SLAT);
    run("rem_m7_0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1, 1'b0, SLAT);
    run("div_min_m1", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, SLAT);
    run("rem_min_m1", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, SLAT);
    run("divu_min_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, LAT);
    // valid pulses during CALC and during the done cycle are both ignored
    issue("divu_busy", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, LAT);
    repeat (5) @(negedge clk);
    opCode = 3'b000;
    lOp = 32'd3;
    rOp = 32'd3;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_done("divu_busy", 1'b1);
    repeat (45) @(negedge clk);
    // reset in the middle of CALC aborts the operation with no done
    @(negedge clk);
    opCode = 3'b011;
    lOp = 32'hFFFF_FFFF;
    rOp = 32'hFFFF_FFFF;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_dz", {31'b0, divByZero}, 32'd0);
    check("abort_ov", {31'b0, divOverflow}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    run("mul_after_rst", 3'b000, 32'd123, 32'd1000, 32'd123000, 1'b0, 1'b0, LAT);
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
